// File: rtl/uart_tx_frame.sv
// UART transmitter: configurable data width, parity and stop bits. Each bit lasts CLKS_PER_BIT cycles.
// The start bit begins one cycle after accept. A one-word holding buffer drops tx_ready_op while full and chains frames with no gap.
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 tx_datav_in,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 tx_ready_op,
    output logic                 op_tx_active,
    output logic                 op_bit,
    output logic                 tx_done_op
);

    localparam int              CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic            PAR_ODD   = (PARITY_MODE == 2);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_par
        $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   buf_q, buf_d;
    logic                   buf_full_q, buf_full_d;
    logic                   bit_q, bit_d;
    logic                   active_q, active_d;
    logic                   done_q, done_d;
    logic                   par_q, par_d;
    logic                   bit_tick;
    logic                   take;

    assign bit_tick     = (cnt_q == CNT_LAST);
    assign tx_ready_op  = ~buf_full_q;
    assign op_tx_active = active_q;
    assign op_bit       = bit_q;
    assign tx_done_op   = done_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            bit_q      <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            par_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            bit_q      <= bit_d;
            active_q   <= active_d;
            done_q     <= done_d;
            par_q      <= par_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        bit_d      = bit_q;
        active_d   = active_q;
        done_d     = 1'b0;
        par_d      = par_q;
        take       = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = bit_tick ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                bit_d    = 1'b1;
                active_d = 1'b0;
                cnt_d    = '0;
                take     = buf_full_q;
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                    bit_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
                        if (PARITY_MODE != 0) begin
                            state_d = PARITY;
                            bit_d   = par_q;
                        end else begin
                            state_d = STOP;
                            bit_d   = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        bit_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                    idx_d   = '0;
                    bit_d   = 1'b1;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (idx_q == STOP_LAST) begin
                        done_d = 1'b1;
                        idx_d  = '0;
                        // A buffered word chains straight into its start bit.
                        if (buf_full_q) begin
                            take = 1'b1;
                        end else begin
                            state_d  = IDLE;
                            active_d = 1'b0;
                            bit_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take) begin
            shift_d    = buf_q;
            par_d      = (^buf_q) ^ PAR_ODD;
            buf_full_d = 1'b0;
            state_d    = START;
            bit_d      = 1'b0;
            active_d   = 1'b1;
            cnt_d      = '0;
        end

        // Accept and take are exclusive: accept needs an empty buffer, take a full one.
        if (tx_datav_in && !buf_full_q) begin
            buf_d      = in_data;
            buf_full_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: 8N1, 7E2 and 7O2 instances at four clocks per bit.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vld;
    logic [7:0] dat;
    logic       rdy, act, line, done;
    logic       vld_p;
    logic [6:0] dat_p;
    logic       rdy_e, act_e, line_e, done_e;
    logic       rdy_o, act_o, line_o, done_o;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut (
        .clk_in(clk), .rst_n_in(rst_n), .tx_datav_in(vld), .in_data(dat),
        .tx_ready_op(rdy), .op_tx_active(act), .op_bit(line), .tx_done_op(done)
    );

    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u_dut_e (
        .clk_in(clk), .rst_n_in(rst_n), .tx_datav_in(vld_p), .in_data(dat_p),
        .tx_ready_op(rdy_e), .op_tx_active(act_e), .op_bit(line_e), .tx_done_op(done_e)
    );

    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_dut_o (
        .clk_in(clk), .rst_n_in(rst_n), .tx_datav_in(vld_p), .in_data(dat_p),
        .tx_ready_op(rdy_o), .op_tx_active(act_o), .op_bit(line_o), .tx_done_op(done_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the edge that accepts the word on vld/dat.
    task automatic wait_acc(input string tag);
        logic a;
        int   n;
        a = 1'b0;
        n = 0;
        while (!a && n < 10) begin
            a = rdy;
            tick();
            n++;
        end
        chk({tag, "_acc"}, a, 1);
    endtask

    task automatic send_frame(input logic [7:0] w, input string tag);
        logic [9:0] f;
        f   = {1'b1, w, 1'b0};
        vld = 1'b1;
        dat = w;
        wait_acc(tag);
        vld = 1'b0;
        dat = ~w;
        chk({tag, "_rdy_full"}, rdy, 0);
        for (int c = 1; c <= 40; c++) begin
            tick();
            chk({tag, "_line"}, line, f[(c-1)/4]);
            chk({tag, "_act"}, act, 1);
            chk({tag, "_done_early"}, done, 0);
            if (c == 1) chk({tag, "_rdy_again"}, rdy, 1);
        end
        tick();
        chk({tag, "_done"}, done, 1);
        chk({tag, "_act_end"}, act, 0);
        chk({tag, "_line_end"}, line, 1);
        tick();
        chk({tag, "_done_1cyc"}, done, 0);
    endtask

    // Two queued frames; toggle mode keeps vld high and wiggles dat while the buffer is full.
    task automatic two_frames(input logic [7:0] w0, input logic [7:0] w1, input bit toggle,
                              input string tag);
        logic [19:0] f;
        logic        a;
        int          nacc;
        f   = {1'b1, w1, 1'b0, 1'b1, w0, 1'b0};
        vld = 1'b1;
        dat = w0;
        wait_acc(tag);
        dat = toggle ? 8'h99 : w1;
        chk({tag, "_rdy_full"}, rdy, 0);
        nacc = 0;
        for (int c = 1; c <= 81; c++) begin
            a = vld & rdy;
            tick();
            if (a) begin
                nacc++;
                chk({tag, "_acc_edge"}, c, 2);
                if (!toggle) vld = 1'b0;
            end
            if (toggle) begin
                if (c == 1) dat = w1;
                else dat = c[0] ? 8'hFF : 8'h00;
                if (c == 40) vld = 1'b0;
            end
            if (c <= 80) begin
                chk({tag, "_line"}, line, f[(c-1)/4]);
                chk({tag, "_act"}, act, 1);
            end else begin
                chk({tag, "_line_end"}, line, 1);
                chk({tag, "_act_end"}, act, 0);
            end
            chk({tag, "_done"}, done, (c == 41 || c == 81));
            chk({tag, "_rdy"}, rdy, !(c >= 2 && c <= 40));
        end
        chk({tag, "_n_acc"}, nacc, 1);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk({tag, "_quiet_line"}, line, 1);
            chk({tag, "_quiet_done"}, done, 0);
            chk({tag, "_quiet_act"}, act, 0);
        end
    endtask

    initial begin
        logic [10:0] fe, fo;
        logic        a;

        rst_n = 1'b0;
        vld   = 1'b0;
        dat   = 8'h00;
        vld_p = 1'b0;
        dat_p = 7'h00;
        tick();
        tick();
        chk("rst_line", line, 1);
        chk("rst_act", act, 0);
        chk("rst_done", done, 0);
        chk("rst_rdy", rdy, 1);
        chk("rst_line_e", line_e, 1);
        chk("rst_rdy_o", rdy_o, 1);
        rst_n = 1'b1;

        for (int c = 0; c < 20; c++) begin
            tick();
            chk("idle_line", line, 1);
            chk("idle_act", act, 0);
            chk("idle_done", done, 0);
            chk("idle_rdy", rdy, 1);
        end

        send_frame(8'hA5, "a5");

        // 0x41 has two set bits among seven: even parity 0, odd parity 1.
        fe    = {2'b11, 1'b0, 7'h41, 1'b0};
        fo    = {2'b11, 1'b1, 7'h41, 1'b0};
        vld_p = 1'b1;
        dat_p = 7'h41;
        chk("par_rdy_e", rdy_e, 1);
        chk("par_rdy_o", rdy_o, 1);
        tick();
        vld_p = 1'b0;
        dat_p = 7'h00;
        for (int c = 1; c <= 44; c++) begin
            tick();
            chk("even_line", line_e, fe[(c-1)/4]);
            chk("odd_line", line_o, fo[(c-1)/4]);
            chk("par_act", act_e & act_o, 1);
            chk("par_done_early", done_e | done_o, 0);
        end
        tick();
        chk("even_done", done_e, 1);
        chk("odd_done", done_o, 1);
        chk("even_act_end", act_e, 0);
        chk("odd_act_end", act_o, 0);

        two_frames(8'h55, 8'h0F, 1'b0, "b2b");
        two_frames(8'h3C, 8'hC3, 1'b1, "bp");

        // Reset in the middle of DATA with a second word waiting in the buffer.
        vld = 1'b1;
        dat = 8'h5A;
        wait_acc("mid");
        dat = 8'h81;
        for (int c = 1; c <= 10; c++) begin
            a = vld & rdy;
            tick();
            if (a) vld = 1'b0;
        end
        chk("mid_buffered", rdy, 0);
        chk("mid_vld_taken", vld, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_line", line, 1);
        chk("mid_rst_act", act, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_rdy", rdy, 1);
        for (int c = 0; c < 60; c++) begin
            tick();
            chk("mid_quiet_line", line, 1);
            chk("mid_quiet_done", done, 0);
            chk("mid_quiet_act", act, 0);
        end
        send_frame(8'hE7, "after_rst");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Data width, parity mode and stop-bit count are set at elaboration. A one-entry holding buffer with a ready/valid handshake lets frames go out back-to-back with no idle gap. It sits between a byte-producing client (command/response logic) and the board TX pin.

Parameters:
CLKS_PER_BIT, 868, clk_in cycles per bit (115200 baud at 100 MHz); legal range >= 2.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame; legal range 1..2.

Ports:
clk_in  input  1  sole clock; all logic on its rising edge.
rst_n_in  input  1  synchronous active-low reset.
tx_datav_in  input  1  client valid; word accepted on an edge where tx_datav_in=1 and tx_ready_op=1.
in_data  input  DATA_BITS  word to send, LSB first.
tx_ready_op  output  1  holding buffer empty; equals not(buffer full).
op_tx_active  output  1  high from the first start-bit cycle to the last stop-bit cycle of the final queued frame.
op_bit  output  1  serial line, registered, idles high.
tx_done_op  output  1  one-cycle pulse per completed frame.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset: on an edge with rst_n_in=0:
  - op_bit=1, op_tx_active=0, tx_done_op=0.
  - Buffer empty, so tx_ready_op=1 from the first cycle after reset.
  - Counters cleared; state IDLE.
- Reset mid-frame: frame is aborted, line returns high at that edge, buffered word is discarded, no tx_done_op pulse.
- Handshake:
  - On an accepting edge, in_data is copied to the buffer. Later changes to in_data have no effect.
  - If tx_datav_in=1 while tx_ready_op=0, nothing is captured and no error is raised.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: op_bit=1. If the buffer is full, at the next edge: load shift register from buffer, empty buffer, go to START, op_bit<=0, op_tx_active<=1.
  - START, DATA, PARITY, STOP: each bit is held exactly CLKS_PER_BIT cycles. The bit counter runs 0..CLKS_PER_BIT-1 and has width $clog2(CLKS_PER_BIT).
  - DATA: DATA_BITS bits, LSB first, then go to PARITY if PARITY_MODE!=0, else STOP.
  - PARITY: even mode sends the XOR of the data bits; odd mode sends its inverse.
  - STOP: line high for STOP_BITS x CLKS_PER_BIT cycles.
- End of the last stop-bit cycle:
  - tx_done_op<=1 for one cycle.
  - If the buffer is full: go directly to START (op_bit<=0, op_tx_active stays 1, no idle cycle).
  - Else: go to IDLE, op_tx_active<=0.
- Latency: accepted at edge k while IDLE, empty buffer → start bit occupies cycles k+1..k+CLKS_PER_BIT; tx_ready_op high again from k+1.
- Frame length: CLKS_PER_BIT x (1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) cycles.
- Illegal parameter values stop elaboration/simulation with a $error.

Test Plan:
- Reset, then idle 20 cycles, no stimulus → op_bit=1, op_tx_active=0, tx_done_op=0, tx_ready_op=1 throughout.
- CLKS_PER_BIT=4, 8N1, accept 0xA5 at edge k → line 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles over k+1..k+40; tx_done_op high only at k+41; op_tx_active low from k+41.
- DATA_BITS=7, PARITY_MODE=1, STOP_BITS=2, send 0x41 → parity bit 0, then 8 high cycles; same with PARITY_MODE=2 → parity bit 1; frame = 44 cycles at CLKS_PER_BIT=4.
- Back-to-back: accept 0x55, then 0x0F one cycle later → second start bit immediately follows first stop bit; op_tx_active never drops; two tx_done_op pulses 40 cycles apart; tx_ready_op low while 0x0F is buffered.
- Backpressure: hold tx_datav_in=1 with buffer full while toggling in_data → only the value present at the accepting edge is transmitted; no extra frames.
- Assert rst_n_in=0 for one edge mid-DATA with a word buffered → op_bit=1 next cycle, no tx_done_op pulse, buffered word never sent, next accepted word sent correctly.
